// File: rtl/svk_ahb_pkg.sv
// Shared AHB (AMBA 2) definitions for the svk_ahb arbiter slice.
// Contents:
//   htrans_e     - HTRANS encodings
//   hburst_e     - HBURST encodings
//   arb_state_e  - arbiter FSM states
//   burst_beats  - beats in a fixed-length burst (1/4/8/16), 0 for INCR (undefined length)

`ifndef SVK_AHB_MAX_NUM_MASTER
`define SVK_AHB_MAX_NUM_MASTER 16
`endif

package svk_ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstWrap4  = 3'b010,
    BurstIncr4  = 3'b011,
    BurstWrap8  = 3'b100,
    BurstIncr8  = 3'b101,
    BurstWrap16 = 3'b110,
    BurstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    StIdle,    // nobody requested, default master holds the grant
    StOwned,   // a requester holds the grant, re-arbitration allowed
    StBurst,   // inside a fixed-length burst
    StLocked   // locked sequence, including the one tail edge after hlock drops
  } arb_state_e;

  function automatic logic [4:0] burst_beats(input hburst_e hburst);
    logic [4:0] beats;
    unique case (hburst)
      BurstSingle:             beats = 5'd1;
      BurstIncr:               beats = 5'd0;
      BurstWrap4, BurstIncr4:  beats = 5'd4;
      BurstWrap8, BurstIncr8:  beats = 5'd8;
      BurstWrap16, BurstIncr16: beats = 5'd16;
      default:                 beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/svk_ahb_rr_picker.sv
// Combinational one-hot priority picker with a rotating start index.
// The first set request found searching upward from `start` (wrapping at NUM_MASTER) wins.
// Ports:
//   req   - per-master request vector
//   start - index searched first; must be < NUM_MASTER
//   gnt   - one-hot winner (all zero when no request)
//   idx   - winner index (0 when no request)
//   valid - at least one request present

module svk_ahb_rr_picker
  import svk_ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTER = 4,
  parameter int unsigned MW         = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [MW-1:0]         start,
  output logic [NUM_MASTER-1:0] gnt,
  output logic [MW-1:0]         idx,
  output logic                  valid
);

  always_comb begin
    int unsigned cand;
    logic [MW-1:0] cand_idx;
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTER; i++) begin
      cand = 32'(start) + i;
      if (cand >= NUM_MASTER) begin
        cand = cand - NUM_MASTER;
      end
      cand_idx = MW'(cand);
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/svk_ahb_arbiter.sv
// AHB (AMBA 2) multi-master bus arbiter, fixed priority (MODE 0) or round-robin (MODE 1).
// Never re-arbitrates inside a fixed-length burst or a locked sequence.
// Supports NUM_MASTER in 1..SVK_AHB_MAX_NUM_MASTER.
// Ports:
//   hclk      - bus clock, rising edge
//   hreset    - synchronous active-high reset
//   hbusreq   - per-master bus request
//   hlock     - per-master lock request
//   htrans    - HTRANS of the current address-phase owner
//   hburst    - HBURST of the current address-phase owner
//   hready    - bus HREADY; an edge with hready=1 accepts a beat
//   hgrant    - registered one-hot grant
//   hmaster   - registered address-phase owner index
//   hmastlock - registered lock flag of the current address phase

module svk_ahb_arbiter
  import svk_ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTER     = 4,
  parameter int unsigned MODE           = 1,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MW             = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [NUM_MASTER-1:0] hbusreq,
  input  logic [NUM_MASTER-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [NUM_MASTER-1:0] hgrant,
  output logic [MW-1:0]         hmaster,
  output logic                  hmastlock
);

  localparam logic [NUM_MASTER-1:0] DefaultGnt = NUM_MASTER'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]         DefaultIdx = MW'(DEFAULT_MASTER);

  arb_state_e            state_q, state_d;
  logic [3:0]            beats_left_q, beats_left_d;
  logic [NUM_MASTER-1:0] gnt_q;
  logic [MW-1:0]         gnt_idx_q;
  logic [MW-1:0]         ptr_q;
  logic [MW-1:0]         hmaster_q;
  logic                  hmastlock_q;

  logic [4:0]            burst_len;
  logic                  lock_cur;
  logic                  arb_en;
  logic [MW-1:0]         pick_start;
  logic [NUM_MASTER-1:0] pick_gnt;
  logic [MW-1:0]         pick_idx;
  logic                  pick_valid;

  assign burst_len = burst_beats(hburst_e'(hburst));
  assign lock_cur  = hlock[gnt_idx_q];

  // Beats still to come after this edge; only accepted beats move it.
  always_comb begin
    beats_left_d = beats_left_q;
    if (hready) begin
      unique case (htrans_e'(htrans))
        TransNonseq: beats_left_d = (burst_len == 5'd0) ? 4'd0 : 4'(burst_len - 5'd1);
        TransSeq:    beats_left_d = (beats_left_q != 4'd0) ? beats_left_q - 4'd1 : 4'd0;
        TransBusy:   beats_left_d = beats_left_q;
        TransIdle:   beats_left_d = 4'd0;
        default:     beats_left_d = 4'd0;
      endcase
    end
  end

  // Fixed priority always searches from 0; round-robin starts one past the last winner.
  always_comb begin
    if (MODE == 0) begin
      pick_start = '0;
    end else begin
      pick_start = (ptr_q == MW'(NUM_MASTER - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  svk_ahb_rr_picker #(
    .NUM_MASTER (NUM_MASTER),
    .MW         (MW)
  ) u_picker (
    .req   (hbusreq),
    .start (pick_start),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // FSM: state register
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. StLocked survives until the first edge that would otherwise be free,
  // so the final locked transfer still completes under the lock.
  always_comb begin
    state_d = state_q;
    if (hready) begin
      if (lock_cur || (state_q == StLocked && beats_left_d > 4'd1)) begin
        state_d = StLocked;
      end else if (beats_left_d > 4'd1) begin
        state_d = StBurst;
      end else if (arb_en && !pick_valid) begin
        state_d = StIdle;
      end else begin
        state_d = StOwned;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    arb_en = hready && (beats_left_d <= 4'd1) && !lock_cur && (state_q != StLocked);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      beats_left_q <= 4'd0;
      gnt_q        <= DefaultGnt;
      gnt_idx_q    <= DefaultIdx;
      ptr_q        <= DefaultIdx;
      hmaster_q    <= DefaultIdx;
      hmastlock_q  <= 1'b0;
    end else begin
      beats_left_q <= beats_left_d;
      if (arb_en) begin
        if (pick_valid) begin
          gnt_q     <= pick_gnt;
          gnt_idx_q <= pick_idx;
          ptr_q     <= pick_idx;
        end else begin
          gnt_q     <= DefaultGnt;
          gnt_idx_q <= DefaultIdx;
        end
      end
      // The address phase that starts now belongs to whoever held the grant before this edge.
      if (hready) begin
        hmaster_q   <= gnt_idx_q;
        hmastlock_q <= lock_cur;
      end
    end
  end

  assign hgrant    = gnt_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_svk_ahb_arbiter.sv
// Bench for svk_ahb_arbiter: a fixed-priority and a round-robin instance share one stimulus
// stream and are both compared every cycle against an integer-level reference model, with
// directed scenarios first and a randomized run after.

module tb_svk_ahb_arbiter;
  import svk_ahb_pkg::*;

  localparam int N   = 4;
  localparam int DEF = 2;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [N-1:0] hbusreq, hlock;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;

  logic [N-1:0] fp_hgrant, rr_hgrant;
  logic [1:0]   fp_hmaster, rr_hmaster;
  logic         fp_hmastlock, rr_hmastlock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = fixed priority, 1 = round-robin
  int m_gnt[2];
  int m_last[2];
  int m_hm[2];
  bit m_hml[2];
  bit m_tail[2];
  int m_beats;
  int len_tab[8] = '{1, 0, 4, 4, 8, 8, 16, 16};
  int exp_rr[5]  = '{3, 0, 1, 2, 3};

  always #5 hclk = ~hclk;

  svk_ahb_arbiter #(
    .NUM_MASTER     (N),
    .MODE           (0),
    .DEFAULT_MASTER (DEF)
  ) dut_fp (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (fp_hgrant),
    .hmaster   (fp_hmaster),
    .hmastlock (fp_hmastlock)
  );

  svk_ahb_arbiter #(
    .NUM_MASTER     (N),
    .MODE           (1),
    .DEFAULT_MASTER (DEF)
  ) dut_rr (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (rr_hgrant),
    .hmaster   (rr_hmaster),
    .hmastlock (rr_hmastlock)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int mode, input int last, input logic [N-1:0] req);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (mode == 1) ? (last + k) % N : k - 1;
      if (req[c]) return c;
    end
    return DEF;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_gnt[m]  = DEF;
      m_last[m] = DEF;
      m_hm[m]   = DEF;
      m_hml[m]  = 1'b0;
      m_tail[m] = 1'b0;
    end
    m_beats = 0;
  endtask

  // One rising edge of the reference, evaluated from the inputs held across that edge.
  task automatic model_edge();
    int  nb;
    bit  lk, free;
    if (hreset) begin
      model_reset();
      return;
    end
    if (!hready) return;
    case (htrans)
      2'b00:   nb = 0;
      2'b01:   nb = m_beats;
      2'b10:   nb = (len_tab[hburst] == 0) ? 0 : len_tab[hburst] - 1;
      default: nb = (m_beats > 0) ? m_beats - 1 : 0;
    endcase
    for (int m = 0; m < 2; m++) begin
      lk   = hlock[m_gnt[m]];
      free = (nb <= 1) && !lk;
      m_hm[m]  = m_gnt[m];
      m_hml[m] = lk;
      if (free && !m_tail[m]) begin
        if (hbusreq == '0) begin
          m_gnt[m] = DEF;
        end else begin
          m_gnt[m]  = pick(m, m_last[m], hbusreq);
          m_last[m] = m_gnt[m];
        end
      end
      if (lk) m_tail[m] = 1'b1;
      else if (free) m_tail[m] = 1'b0;
    end
    m_beats = nb;
  endtask

  task automatic compare_all();
    check("fp_hgrant",    32'(fp_hgrant),    32'(1) << m_gnt[0]);
    check("fp_hmaster",   32'(fp_hmaster),   32'(m_hm[0]));
    check("fp_hmastlock", 32'(fp_hmastlock), 32'(m_hml[0]));
    check("rr_hgrant",    32'(rr_hgrant),    32'(1) << m_gnt[1]);
    check("rr_hmaster",   32'(rr_hmaster),   32'(m_hm[1]));
    check("rr_hmastlock", 32'(rr_hmastlock), 32'(m_hml[1]));
  endtask

  task automatic step();
    @(posedge hclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] lck, input htrans_e tr,
                        input hburst_e bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
  endtask

  initial begin
    model_reset();
    set_in('0, '0, TransIdle, BurstSingle, 1'b1);
    hreset = 1'b1;
    step();
    step();
    check("rst_hgrant",    32'(fp_hgrant),    32'h4);
    check("rst_hmaster",   32'(fp_hmaster),   32'd2);
    check("rst_hmastlock", 32'(fp_hmastlock), 32'd0);
    check("rst_rr_hgrant", 32'(rr_hgrant),    32'h4);
    hreset = 1'b0;

    // Round-robin rotation under a constant full request, SINGLE transfers
    set_in(4'b1111, '0, TransNonseq, BurstSingle, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_rotation", 32'(rr_hgrant), 32'(1) << exp_rr[i]);
      check("fp_lowest",   32'(fp_hgrant), 32'h1);
    end

    // M1 INCR8 with a BUSY, M0 requesting from the first beat on
    do_reset();
    set_in(4'b0010, '0, TransIdle, BurstIncr8, 1'b1);
    step();
    step();
    check("incr8_owner", 32'(fp_hmaster), 32'd1);
    hbusreq = 4'b0011;
    for (int i = 0; i < 9; i++) begin
      htrans = (i == 0) ? TransNonseq : (i == 3) ? TransBusy : TransSeq;
      step();
      check("incr8_hgrant", 32'(fp_hgrant), (i < 7) ? 32'h2 : 32'h1);
      if (i == 7) check("incr8_hmaster_last", 32'(fp_hmaster), 32'd1);
      if (i == 8) check("incr8_hmaster_next", 32'(fp_hmaster), 32'd0);
    end

    // Reset in the middle of an INCR8 clears the beat counter too
    set_in(4'b0010, '0, TransNonseq, BurstIncr8, 1'b1);
    step();
    htrans = TransSeq;
    step();
    do_reset();
    check("midrst_hgrant",    32'(fp_hgrant),    32'h4);
    check("midrst_hmaster",   32'(fp_hmaster),   32'd2);
    check("midrst_hmastlock", 32'(fp_hmastlock), 32'd0);
    step();
    check("midrst_rearb", 32'(fp_hgrant), 32'h2);

    // M3 locked for 3 transfers while M0 requests
    do_reset();
    set_in(4'b1000, 4'b1000, TransIdle, BurstSingle, 1'b1);
    step();
    check("lock_grant", 32'(fp_hgrant), 32'h8);
    step();
    check("lock_hmaster",   32'(fp_hmaster),   32'd3);
    check("lock_hmastlock", 32'(fp_hmastlock), 32'd1);
    hbusreq = 4'b1001;
    htrans  = TransNonseq;
    step();
    step();
    check("lock_hold",      32'(fp_hgrant),    32'h8);
    check("lock_hmastlock", 32'(fp_hmastlock), 32'd1);
    hlock = '0;
    step();
    check("lock_tail",        32'(fp_hgrant),    32'h8);
    check("lock_tail_unlock", 32'(fp_hmastlock), 32'd0);
    step();
    check("lock_release", 32'(fp_hgrant), 32'h1);

    // hready low freezes everything while requests move
    do_reset();
    set_in(4'b0001, '0, TransSeq, BurstSingle, 1'b0);
    for (int i = 0; i < 5; i++) begin
      hbusreq = 4'($urandom_range(1, 15));
      step();
      check("freeze_hgrant",  32'(fp_hgrant),  32'h4);
      check("freeze_hmaster", 32'(fp_hmaster), 32'd2);
    end
    hbusreq = 4'b0001;
    hready  = 1'b1;
    step();
    check("freeze_release", 32'(fp_hgrant),  32'h1);
    check("freeze_owner",   32'(fp_hmaster), 32'd2);
    step();
    check("freeze_owner_next", 32'(fp_hmaster), 32'd0);

    // No requests: back to the default master
    hbusreq = '0;
    step();
    check("default_return", 32'(fp_hgrant), 32'h4);

    // IDLE in the middle of a WRAP4 ends the burst at once
    set_in(4'b0010, '0, TransIdle, BurstWrap4, 1'b1);
    step();
    hbusreq = 4'b0011;
    htrans  = TransNonseq;
    step();
    check("wrap4_hold", 32'(fp_hgrant), 32'h2);
    htrans = TransSeq;
    step();
    check("wrap4_hold2", 32'(fp_hgrant), 32'h2);
    htrans = TransIdle;
    step();
    check("wrap4_early_end", 32'(fp_hgrant), 32'h1);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      hreset  = ($urandom_range(0, 299) == 0);
      hbusreq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) hlock = ($urandom_range(0, 1) == 0) ? 4'($urandom) : '0;
      r = int'($urandom_range(0, 15));
      htrans  = (r < 2) ? TransNonseq : (r == 2) ? TransIdle : (r == 3) ? TransBusy : TransSeq;
      hburst  = 3'($urandom);
      hready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
